// File: rtl/fixed_divider.sv
// Sequential restoring divider for signed Q17.15 operands. It works on magnitudes,
// produces one quotient bit per enabled cycle, then applies the sign and saturates.
module fixed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        dbz
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one restoring step per enabled edge, 47 steps
  // DONE  | first edge: publish result and pulse done; second edge: back to IDLE
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [46:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_q, neg_d;
  logic        sa_q, sa_d;
  logic        zero_q, zero_d;
  logic [31:0] q_q, q_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] trial, diff;
  logic        fit;
  logic [31:0] q_neg;
  logic        pos_sat, neg_sat;

  always_comb begin
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    // remainder stays below the divisor (<= 2^31), so the trial value fits 32 bits
    trial = {rem_q, dvd_q[46]};
    diff  = trial - {1'b0, dvs_q};
    fit   = ~diff[32];
    q_neg = ~dvd_q[31:0] + 32'd1;
    pos_sat = |dvd_q[46:31];
    neg_sat = (|dvd_q[46:32]) || (dvd_q[31] && (|dvd_q[30:0]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    zero_d  = zero_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = done_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_d   = a[31] ^ b[31];
            sa_d    = a[31];
            zero_d  = (b == 32'd0);
            dvd_d   = {mag_a, 15'd0};
            dvs_d   = mag_b;
            rem_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = (b == 32'd0) ? DONE : CALC;
          end
        end
        CALC: begin
          rem_d = fit ? diff[31:0] : trial[31:0];
          dvd_d = {dvd_q[45:0], fit};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd46) state_d = DONE;
        end
        DONE: begin
          if (!done_q) begin
            done_d = 1'b1;
            dbz_d  = zero_q;
            if (zero_q) begin
              ovf_d = 1'b0;
              q_d   = sa_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (neg_q) begin
              ovf_d = neg_sat;
              q_d   = neg_sat ? 32'h8000_0000 : q_neg;
            end else begin
              ovf_d = pos_sat;
              q_d   = pos_sat ? 32'h7FFF_FFFF : dvd_q[31:0];
            end
          end else begin
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      dvd_q   <= 47'd0;
      dvs_q   <= 32'd0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= 32'd0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_divider.sv
// Directed and random checks of fixed_divider: expected results are queued at start
// and compared when done pulses, including latency, stalls, reset abort and saturation.
module tb_fixed_divider;

  logic        clk = 1'b0;
  logic        rst, ce, start;
  logic [31:0] a, b, q;
  logic        busy, done, ovf, dbz;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  fixed_divider dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .a(a), .b(b),
    .q(q), .busy(busy), .done(done), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // reference built on wide integer division rather than a bit-serial loop
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rq, output logic rovf, output logic rdbz,
                         output int rlat);
    logic [63:0] ma, mb, qq;
    logic        neg;
    neg = x[31] ^ y[31];
    ma  = {32'd0, (x[31] ? -x : x)};
    mb  = {32'd0, (y[31] ? -y : y)};
    if (y == 32'd0) begin
      rq = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      rovf = 1'b0; rdbz = 1'b1; rlat = 1;
    end else begin
      qq = (ma << 15) / mb;
      rdbz = 1'b0; rlat = 48;
      if (!neg) begin
        rovf = (qq > 64'h7FFF_FFFF);
        rq   = rovf ? 32'h7FFF_FFFF : qq[31:0];
      end else begin
        rovf = (qq > 64'h8000_0000);
        rq   = rovf ? 32'h8000_0000 : (32'd0 - qq[31:0]);
      end
    end
  endtask

  task automatic run(input logic [31:0] ta, input logic [31:0] tbv,
                     input logic [31:0] eq, input logic eovf, input logic edbz,
                     input int elat, input int stall_at, input int spulse);
    exp_t e;
    int   cyc;
    bit   got;
    e.q = eq; e.ovf = eovf; e.dbz = edbz; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tbv;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      ce    = (cyc >= stall_at && cyc < stall_at + 10) ? 1'b0 : 1'b1;
      start = (cyc == spulse);
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) got = 1;
    end
    ce = 1'b1; start = 1'b0;
    e = sb.pop_front();
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(e.lat));
    check("q", q, e.q);
    check("ovf", 32'(ovf), 32'(e.ovf));
    check("dbz", 32'(dbz), 32'(e.dbz));
    check("busy_at_done", 32'(busy), 32'd1);
    // start coinciding with the DONE->IDLE edge must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_fall", 32'(busy), 32'd0);
    check("done_width", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("start_on_exit_ignored", 32'(busy), 32'd0);
    check("q_hold", q, e.q);
  endtask

  initial begin
    logic [31:0] rq, ra, rb;
    logic        rovf, rdbz;
    int          rlat;
    bit          seen;

    rst = 1'b1; ce = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("rst_q", q, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst = 1'b0;

    run(32'h0001_8000, 32'h0000_8000, 32'h0001_8000, 1'b0, 1'b0, 48, -100, -1);
    run(32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 48, -100, -1);
    run(32'hFFFD_0000, 32'h0001_0000, 32'hFFFE_8000, 1'b0, 1'b0, 48, -100, -1);
    run(32'hFFFF_8000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1, -100, -1);
    run(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, -100, -1);
    run(32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0, 48, -100, -1);
    run(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 48, -100, -1);
    // ce stall of 10 cycles mid-CALC plus a start pulse while busy
    run(32'h0001_8000, 32'h0000_8000, 32'h0001_8000, 1'b0, 1'b0, 58, 20, 5);
    run(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 48, -100, -1);
    run(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 48, -100, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 24);
      ref_div(ra, rb, rq, rovf, rdbz, rlat);
      run(ra, rb, rq, rovf, rdbz, rlat, -100, -1);
    end

    run(32'h8000_0000, 32'hFFFF_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, 48, -100, -1);

    // reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    a = 32'h0001_8000; b = 32'h0000_8000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_q", q, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run(32'h0001_8000, 32'h0000_8000, 32'h0001_8000, 1'b0, 1'b0, 48, -100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_divider.md
FIXED_DIVIDER -- requirements
Module: fixed_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide the following ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- ce  input  1  clock enable; when low, all state, outputs and counters hold.
- start  input  1  request a division; sampled only in IDLE with ce high.
- a  input  32  dividend, signed two's complement, 17 integer bits and 15 fraction bits (Q17.15).
- b  input  32  divisor, signed Q17.15.
- q  output  32  quotient, signed Q17.15.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse marking q valid.
- ovf  output  1  quotient saturated; valid with done.
- dbz  output  1  divide by zero; valid with done.

Function
REQ-003 The block SHALL compute q = a/b in Q17.15, truncated toward zero.
REQ-004 The block SHALL use a sequential restoring algorithm on magnitudes:
- dividend magnitude |a|·2^15 is 47 bits;
- divisor magnitude |b| is 32 bits unsigned;
- |0x80000000| = 2^31, handled without loss.
REQ-005 The block SHALL produce one quotient bit per enabled cycle, MSB first, for 47 iterations.
REQ-006 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-007 IDLE SHALL transition to CALC on start=1 with ce=1, and in that same edge:
- latch a and b;
- latch the result sign (sign of a XOR sign of b);
- load the magnitudes;
- clear the iteration counter.
REQ-008 In CALC, each enabled edge SHALL perform exactly one shift/compare/subtract step; after the 47th step the FSM SHALL go to DONE.
REQ-009 On entry to DONE the block SHALL:
- apply sign and saturation;
- update q, ovf and dbz;
- assert done for exactly one enabled cycle;
- return to IDLE on the next enabled edge.
REQ-010 Latency SHALL be as follows, counting enabled edges:
- the start-sampling edge is edge 0;
- the 47 CALC steps occur on edges 1–47;
- q, ovf, dbz and done update on edge 48;
- busy falls on edge 49.
REQ-011 Saturation SHALL work on the unsigned magnitude quotient Q:
- positive result with Q > 0x7FFFFFFF → q = 0x7FFFFFFF, ovf = 1;
- negative result with Q > 0x80000000 → q = 0x80000000, ovf = 1;
- otherwise q = ±Q and ovf = 0.
REQ-012 A negative result with Q = 0 SHALL give q = 0x00000000.
REQ-013 A divisor of b = 0 SHALL skip CALC:
- IDLE → DONE on the start edge;
- done pulses on edge 1;
- dbz = 1 and ovf = 0;
- q = 0x7FFFFFFF if a ≥ 0, else q = 0x80000000.
REQ-014 start SHALL be ignored while busy=1; changes on a and b after the start edge SHALL NOT affect the result in progress.
REQ-015 The outputs q, ovf and dbz SHALL hold their last values until the next done.
REQ-016 With ce=0, the FSM, counter, datapath registers and done SHALL freeze:
- a done pulse in progress lasts until the next enabled edge;
- no operation is lost.
REQ-017 If start and the return DONE→IDLE occur on the same edge, start SHALL be ignored; a new start is accepted only from IDLE.

Reset
REQ-018 Asserting rst SHALL immediately, without a clock edge, set:
- FSM = IDLE;
- busy = 0, done = 0;
- q = 0x00000000;
- ovf = 0, dbz = 0;
- iteration counter and datapath registers = 0.
REQ-019 A reset mid-operation SHALL abort the division:
- no done pulse is produced for the aborted operation;
- after rst deasserts, the first start is accepted normally.

Verification
REQ-020 a=0x00018000 (3.0), b=0x00008000 (1.0), start → done on edge 48, q=0x00018000, ovf=0, dbz=0.
REQ-021 a=0x00008000 (1.0), b=0x00018000 (3.0) → q=0x00002AAA; a=0xFFFD0000 (−6.0), b=0x00010000 (2.0) → q=0xFFFE8000.
REQ-022 a=0x7FFFFFFF, b=0x00000001 → q=0x7FFFFFFF, ovf=1; a=0x80000000, b=0x00000001 → q=0x80000000, ovf=1.
REQ-023 a=0xFFFF8000 (−1.0), b=0 → done on edge 1, q=0x80000000, dbz=1, busy low on edge 2.
REQ-024 ce low for 10 cycles mid-CALC → done delayed by exactly 10 cycles, same q; start pulsed while busy → ignored, a single done.
REQ-025 rst pulsed at CALC step 20 → all outputs zero asynchronously, no done; the next start with a=0x00018000, b=0x00008000 gives q=0x00018000 on edge 48.
